// File: rtl/pc_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg
// Shared types and defaults for the fetch-stage program counter sequencer.
//   pc_sel_e   : next-PC source select
//   pc_state_e : sequencer FSM states
//   DEF_*      : default parameter values for pc_sequencer / pc_ras
//   misaligned(): true when a word-addressed target carries nonzero bits[1:0]
// No ports (package).
// ----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_RST,
        SEL_EXC,
        SEL_BR,
        SEL_JMP,
        SEL_RAS,
        SEL_HOLD,
        SEL_INC
    } pc_sel_e;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } pc_state_e;

    localparam int          DEF_WIDTH     = 32;
    localparam int          DEF_INC       = 4;
    localparam logic [31:0] DEF_RESET_VEC = 32'd100;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;
    localparam int          DEF_RAS_DEPTH = 4;

    function automatic logic misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// ----------------------------------------------------------------------------
// pc_ras
// Return-address stack for the PC sequencer. Circular buffer of RAS_DEPTH
// entries with a write pointer and a saturating occupancy count; pushing
// when full overwrites the oldest entry.
// Ports:
//   Clk          in   clock, rising edge
//   Rst          in   synchronous reset, active-high (empties the stack)
//   i_push       in   push i_push_data
//   i_pop        in   pop top entry (ignored when empty)
//   i_push_data  in   WIDTH  value to push
//   o_top        out  WIDTH  current top entry (valid when !o_empty)
//   o_empty      out  stack holds no entries
// push+pop together on a non-empty stack replaces the top entry in place.
// ----------------------------------------------------------------------------
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_top_idx;

    // r_ptr is the next write slot; the depth is a power of two so the
    // pointer wraps naturally.
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = (r_count == '0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && i_pop && !o_empty) begin
            r_mem[w_top_idx] <= i_push_data;
        end else if (i_push) begin
            r_mem[r_ptr] <= i_push_data;
            r_ptr        <= r_ptr + PTR_W'(1);
            if (r_count != CNT_FULL) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Fetch-stage program counter. Holds PC and picks the next PC from reset,
// exception vector, branch, jump, return-address prediction, hold, or PC+INC.
// Optional feature macro: PC_RAS_EN (return-address stack via pc_ras).
// Ports:
//   Clk          in   clock, rising edge
//   Rst          in   synchronous reset, active-high
//   Stall        in   hold PC this cycle
//   ExcReq       in   redirect to EXC_VEC
//   BranchTaken  in   redirect to BranchTarget (bits[1:0] forced 0)
//   BranchTarget in   WIDTH
//   Jump         in   redirect to JumpTarget (bits[1:0] forced 0)
//   JumpTarget   in   WIDTH
//   Call         in   push PC+INC on the RAS (PC_RAS_EN only)
//   Ret          in   pop RAS and predict target (PC_RAS_EN only)
//   PC           out  WIDTH  current fetch address
//   PCPlusInc    out  WIDTH  PC + INC, wraps
//   PCValid      out  PC holds a fetchable address
//   AlignErr     out  one-cycle pulse: taken branch/jump target misaligned
//   RasMiss      out  one-cycle pulse: Ret on empty RAS
//
// state | meaning
// BOOT  | first cycle out of reset; PC held, PCValid still low
// RUN   | fetching; PC advances or redirects every cycle
// HOLD  | stalled with no redirect; PC held, PCValid stays high
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               INC       = DEF_INC,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter int               RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Stall,
    input  logic             ExcReq,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Call,
    input  logic             Ret,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlusInc,
    output logic             PCValid,
    output logic             AlignErr,
    output logic             RasMiss
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    pc_state_e        r_state;
    pc_state_e        w_state_nxt;
    pc_sel_e          w_sel;
    logic [WIDTH-1:0] r_pc;
    logic             r_pc_valid;
    logic             r_align_err;
    logic             r_ras_miss;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_pc_plus_inc;
    logic [WIDTH-1:0] w_br_tgt;
    logic [WIDTH-1:0] w_jmp_tgt;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_empty;
    logic             w_ret_act;
    logic             w_redirect;
    logic             w_align_nxt;
    logic             w_ras_miss_nxt;

    assign w_pc_plus_inc = r_pc + INC_W;
    assign w_br_tgt      = {BranchTarget[WIDTH-1:2], 2'b00};
    assign w_jmp_tgt     = {JumpTarget[WIDTH-1:2], 2'b00};
    assign w_redirect    = ExcReq | BranchTaken | Jump;

`ifdef PC_RAS_EN
    logic w_advance;
    logic w_call_act;

    // RAS only moves when the fetched instruction actually advances: not in
    // BOOT, not stalled, and not squashed by a later-stage redirect.
    assign w_advance  = (r_state != BOOT) && !Stall && !w_redirect;
    assign w_call_act = Call & w_advance;
    assign w_ret_act  = Ret & w_advance;

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .Clk         (Clk),
        .Rst         (Rst),
        .i_push      (w_call_act),
        .i_pop       (w_ret_act),
        .i_push_data (w_pc_plus_inc),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty)
    );
`else
    logic w_unused_ras;

    assign w_unused_ras = Call ^ Ret;
    assign w_ret_act    = 1'b0;
    assign w_ras_top    = '0;
    assign w_ras_empty  = 1'b1;
`endif

    always_comb begin
        w_sel          = SEL_INC;
        w_state_nxt    = r_state;
        w_ras_miss_nxt = 1'b0;

        if (Rst) begin
            w_sel       = SEL_RST;
            w_state_nxt = BOOT;
        end else if (r_state == BOOT) begin
            w_sel       = SEL_HOLD;
            w_state_nxt = RUN;
        end else begin
            if (ExcReq) begin
                w_sel = SEL_EXC;
            end else if (BranchTaken) begin
                w_sel = SEL_BR;
            end else if (Jump) begin
                w_sel = SEL_JMP;
            end else if (w_ret_act && !w_ras_empty) begin
                w_sel = SEL_RAS;
            end else if (Stall) begin
                w_sel = SEL_HOLD;
            end else begin
                w_sel = SEL_INC;
            end
            w_state_nxt    = (Stall && !w_redirect) ? HOLD : RUN;
            // Ret with an empty stack falls through to PC+INC.
            w_ras_miss_nxt = w_ret_act && w_ras_empty;
        end

        w_align_nxt = 1'b0;
        case (w_sel)
            SEL_RST:  w_pc_nxt = RESET_VEC;
            SEL_EXC:  w_pc_nxt = EXC_VEC;
            SEL_BR: begin
                w_pc_nxt    = w_br_tgt;
                w_align_nxt = misaligned(BranchTarget[1:0]);
            end
            SEL_JMP: begin
                w_pc_nxt    = w_jmp_tgt;
                w_align_nxt = misaligned(JumpTarget[1:0]);
            end
            SEL_RAS:  w_pc_nxt = w_ras_top;
            SEL_HOLD: w_pc_nxt = r_pc;
            default:  w_pc_nxt = w_pc_plus_inc;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= BOOT;
            r_pc        <= RESET_VEC;
            r_pc_valid  <= 1'b0;
            r_align_err <= 1'b0;
            r_ras_miss  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            // Valid rises one cycle after leaving BOOT.
            r_pc_valid  <= (r_state != BOOT);
            r_align_err <= w_align_nxt;
            r_ras_miss  <= w_ras_miss_nxt;
        end
    end

    assign PC        = r_pc;
    assign PCPlusInc = w_pc_plus_inc;
    assign PCValid   = r_pc_valid;
    assign AlignErr  = r_align_err;
    assign RasMiss   = r_ras_miss;

endmodule
